out_wrapper_controller: RTL and testbench

//   Output wrapper for the IMC, downstream of the IMC macro and mirroring the input wrapper.
//   - Captures one N_WORDS-wide IMC result vector when the IMC pulses done.
//   - Streams the words out one per handshake over a valid/accept interface.
//   - Holds imc_ready_o low until the full vector has drained, so the input wrapper cannot

---
 rtl/out_wrapper_controller.sv | 111 +++++++++++
 tb/tb_out_wrapper_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/out_wrapper_controller.sv
// Output wrapper for the IMC: captures one result vector on imc_done_i and streams it
// out word by word over a valid/accept handshake, blocking new IMC starts until drained.
module out_wrapper_controller #(
    parameter int DATA_W  = 8,
    parameter int N_WORDS = 4
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        imc_done_i,
    input  logic [N_WORDS*DATA_W-1:0]   imc_result_i,
    output logic                        imc_ready_o,
    output logic [DATA_W-1:0]           data_o,
    output logic                        data_valid_o,
    output logic                        data_last_o,
    input  logic                        data_accept_i,
    output logic                        overrun_o
);

    localparam int CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  buf_q [N_WORDS];
    logic [DATA_W-1:0]  data_q;
    logic               valid_q;
    logic               last_q;
    logic               ready_q;
    logic               overrun_q;
    logic [CNT_W-1:0]   cnt_nxt;

    assign cnt_nxt = cnt_q + 1'b1;

    // Outputs come straight from flops, so none has a combinational path from an input.
    assign imc_ready_o  = ready_q;
    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign data_last_o  = last_q;
    assign overrun_o    = overrun_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            // NOTE: the result buffer is small and must read as zero after reset, so every
            // entry is cleared here; a large RAM would normally be left unreset.
            for (int k = 0; k < N_WORDS; k++) begin
                buf_q[k] <= '0;
            end
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            ready_q   <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every update in this block based on the
            // values from before the edge, regardless of statement order.
            case (state_q)
                IDLE: begin
                    if (imc_done_i) begin
                        for (int k = 0; k < N_WORDS; k++) begin
                            buf_q[k] <= imc_result_i[k*DATA_W +: DATA_W];
                        end
                        cnt_q   <= '0;
                        data_q  <= imc_result_i[DATA_W-1:0];
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= SEND;
                    end
                end

                SEND: begin
                    // A done pulse while occupied is dropped; the buffer keeps streaming.
                    if (imc_done_i) begin
                        overrun_q <= 1'b1;
                    end
                    if (data_accept_i) begin
                        if (cnt_q == LAST_IDX) begin
                            cnt_q   <= '0;
                            data_q  <= '0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            cnt_q   <= cnt_nxt;
                            data_q  <= buf_q[cnt_nxt];
                            last_q  <= (cnt_nxt == LAST_IDX);
                        end
                    end
                end

                default: begin
                    cnt_q   <= '0;
                    data_q  <= '0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_wrapper_controller.sv
// Directed scoreboard bench for out_wrapper_controller (DATA_W=8, N_WORDS=4).
module tb_out_wrapper_controller;

    localparam int DATA_W  = 8;
    localparam int N_WORDS = 4;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              last;
    } exp_t;

    logic                       clk_i = 1'b0;
    logic                       rstn_i = 1'b0;
    logic                       imc_done_i = 1'b0;
    logic [N_WORDS*DATA_W-1:0]  imc_result_i = '0;
    logic                       imc_ready_o;
    logic [DATA_W-1:0]          data_o;
    logic                       data_valid_o;
    logic                       data_last_o;
    logic                       data_accept_i = 1'b0;
    logic                       overrun_o;

    int   checks = 0;
    int   failures = 0;
    int   transfers = 0;
    exp_t sb[$];

    out_wrapper_controller #(.DATA_W(DATA_W), .N_WORDS(N_WORDS)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .imc_done_i   (imc_done_i),
        .imc_result_i (imc_result_i),
        .imc_ready_o  (imc_ready_o),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_last_o  (data_last_o),
        .data_accept_i(data_accept_i),
        .overrun_o    (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_vec(input logic [N_WORDS*DATA_W-1:0] v);
        exp_t e;
        for (int k = 0; k < N_WORDS; k++) begin
            e.d    = v[k*DATA_W +: DATA_W];
            e.last = (k == N_WORDS - 1);
            sb.push_back(e);
        end
    endtask

    // One clock cycle: sample at the falling edge, retire a transfer into the scoreboard,
    // then move to just after the next rising edge where new inputs are driven.
    task automatic cycle();
        exp_t e;
        @(negedge clk_i);
        if (data_valid_o && data_accept_i) begin
            transfers++;
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("data", 32'(data_o), 32'(e.d));
                check("last", 32'(data_last_o), 32'(e.last));
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic load(input logic [N_WORDS*DATA_W-1:0] v);
        imc_done_i   = 1'b1;
        imc_result_i = v;
        push_vec(v);
        cycle();
        imc_done_i   = 1'b0;
        imc_result_i = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rstn_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_ready", 32'(imc_ready_o), 32'd1);
        check("rst_valid", 32'(data_valid_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_last", 32'(data_last_o), 32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);

        // 1: accept tied high, 4 words back to back, ready again at t+5
        data_accept_i = 1'b1;
        load(32'h44332211);
        check("t1_ready_low", 32'(imc_ready_o), 32'd0);
        check("t1_valid", 32'(data_valid_o), 32'd1);
        for (int i = 0; i < N_WORDS; i++) cycle();
        check("t1_drained", 32'(sb.size()), 32'd0);
        check("t1_ready_back", 32'(imc_ready_o), 32'd1);
        check("t1_valid_off", 32'(data_valid_o), 32'd0);
        check("t1_data_idle", 32'(data_o), 32'd0);

        // Accept in IDLE must be ignored
        cycle();
        check("idle_accept_ignored", 32'(data_valid_o), 32'd0);

        // 2: accept toggling 1-0-1-0, held word equals scoreboard head
        transfers = 0;
        load(32'h44332211);
        for (int i = 0; i < 2 * N_WORDS; i++) begin
            data_accept_i = (i % 2 == 0);
            if (!data_accept_i && sb.size() != 0) begin
                check("t2_hold_data", 32'(data_o), 32'(sb[0].d));
                check("t2_hold_last", 32'(data_last_o), 32'(sb[0].last));
            end
            cycle();
        end
        check("t2_transfers", 32'(transfers), 32'd4);
        check("t2_drained", 32'(sb.size()), 32'd0);
        check("t2_ready", 32'(imc_ready_o), 32'd1);

        // 3: no accept for 20 cycles, first word held
        data_accept_i = 1'b0;
        load(32'hDEADBEEF);
        for (int i = 0; i < 20; i++) begin
            check("t3_data", 32'(data_o), 32'hEF);
            check("t3_valid", 32'(data_valid_o), 32'd1);
            check("t3_ready", 32'(imc_ready_o), 32'd0);
            cycle();
        end
        data_accept_i = 1'b1;
        for (int i = 0; i < N_WORDS; i++) cycle();
        check("t3_drained", 32'(sb.size()), 32'd0);

        // 4: done pulse during SEND is dropped and flagged
        check("t4_overrun_pre", 32'(overrun_o), 32'd0);
        load(32'h44332211);
        cycle();
        imc_done_i   = 1'b1;
        imc_result_i = 32'hFFFFFFFF;
        cycle();
        imc_done_i   = 1'b0;
        imc_result_i = '0;
        check("t4_overrun_set", 32'(overrun_o), 32'd1);
        for (int i = 0; i < N_WORDS - 2; i++) cycle();
        check("t4_drained", 32'(sb.size()), 32'd0);
        check("t4_ready", 32'(imc_ready_o), 32'd1);
        for (int i = 0; i < 3; i++) cycle();
        check("t4_overrun_sticky", 32'(overrun_o), 32'd1);
        check("t4_no_reload", 32'(data_valid_o), 32'd0);

        // 5: reset after word 1 accepted aborts the stream
        do_reset();
        check("t5_overrun_cleared", 32'(overrun_o), 32'd0);
        load(32'h44332211);
        cycle();
        cycle();
        rstn_i = 1'b0;
        #1;
        check("t5_valid_async", 32'(data_valid_o), 32'd0);
        check("t5_ready_async", 32'(imc_ready_o), 32'd1);
        check("t5_data_async", 32'(data_o), 32'd0);
        check("t5_last_async", 32'(data_last_o), 32'd0);
        sb.delete();
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        load(32'hA0B0C0D0);
        check("t5_first_word", 32'(data_o), 32'hD0);
        for (int i = 0; i < N_WORDS; i++) cycle();
        check("t5_drained", 32'(sb.size()), 32'd0);

        // 6: done together with the last accept is ignored and flagged
        load(32'h01020304);
        for (int i = 0; i < N_WORDS - 1; i++) cycle();
        check("t6_last_pending", 32'(data_last_o), 32'd1);
        imc_done_i   = 1'b1;
        imc_result_i = 32'h55555555;
        cycle();
        imc_done_i   = 1'b0;
        imc_result_i = '0;
        check("t6_ready", 32'(imc_ready_o), 32'd1);
        check("t6_not_loaded", 32'(data_valid_o), 32'd0);
        check("t6_overrun", 32'(overrun_o), 32'd1);
        check("t6_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
